// File: rtl/beat_sequencer.sv
// beat_sequencer: run-control sequencer for the four-beat machine cycle.
// Define BEAT_SEQ_HALT_EN to honour the datapath halt and panel resume.
module beat_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic             halt,
    input  logic             resume,
    output logic [3:0]       slow,
    output logic             quick,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [1:0]       ph;
    logic [1:0]       ph_n;
    logic             stop_pend;
    logic             pend_n;
    logic [CNT_W-1:0] cnt_n;
    logic             act_n;
    logic [3:0]       slow_n;
    logic             halt_take;
    logic             resume_take;

`ifdef BEAT_SEQ_HALT_EN
    assign halt_take   = halt;
    assign resume_take = resume;
`else
    logic unused_in;
    assign unused_in   = halt ^ resume;
    assign halt_take   = 1'b0;
    // HALTED cannot be entered here; fall back to IDLE if it ever is
    assign resume_take = 1'b1;
`endif

    always_comb begin
        state_n = state;
        ph_n    = ph;
        pend_n  = stop_pend;
        cnt_n   = cycle_cnt;
        unique case (state)
            IDLE: begin
                ph_n   = 2'd0;
                pend_n = 1'b0;
                if (start) begin
                    state_n = RUN;
                end else if (step) begin
                    state_n = STEP;
                end
            end
            RUN, STEP: begin
                pend_n = stop_pend | stop;
                if (ph == 2'd3) begin
                    cnt_n = cycle_cnt + CNT_W'(1);
                    ph_n  = 2'd0;
                    if (halt_take) begin
                        state_n = HALTED;
                    end else if (state == STEP || stop_pend || stop) begin
                        state_n = IDLE;
                    end
                end else begin
                    ph_n = ph + 2'd1;
                end
                if (state_n != RUN && state_n != STEP) begin
                    pend_n = 1'b0;
                end
            end
            HALTED: begin
                ph_n   = 2'd0;
                pend_n = 1'b0;
                if (resume_take) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    assign act_n  = (state_n == RUN) || (state_n == STEP);
    assign slow_n = act_n ? (4'b1000 >> ph_n) : 4'b0000;

    // Outputs are registered from the next-state values so they align with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ph        <= 2'd0;
            stop_pend <= 1'b0;
            cycle_cnt <= '0;
            slow      <= 4'b0000;
            quick     <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            ph        <= ph_n;
            stop_pend <= pend_n;
            cycle_cnt <= cnt_n;
            slow      <= slow_n;
            quick     <= act_n & ~cnt_n[0];
            busy      <= act_n;
            halted    <= (state_n == HALTED);
        end
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: scoreboard bench for beat_sequencer (CNT_W=8 and CNT_W=2).
// Follows BEAT_SEQ_HALT_EN to pick the expected halt behaviour.
module tb_beat_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, step, stop, halt, resume;
    logic [3:0] slow, slow2;
    logic       quick, busy, halted;
    logic       quick2, busy2, halted2;
    logic [7:0] cycle_cnt;
    logic [1:0] cnt2;

    int compared = 0;
    int mismatched = 0;
    int vec_n = 0;
    int b;

    typedef struct packed {
        int         id;
        logic [3:0] s;
        logic       q;
        logic       bz;
        logic       h;
        logic [7:0] c;
    } exp_t;

    exp_t q_exp[$];

    localparam logic [4:0] N  = 5'b00000;
    localparam logic [4:0] ST = 5'b10000;
    localparam logic [4:0] SP = 5'b01000;
    localparam logic [4:0] SO = 5'b00100;
    localparam logic [4:0] HL = 5'b00010;
    localparam logic [4:0] RS = 5'b00001;
    localparam logic [3:0] Z  = 4'b0000;
    localparam logic [3:0] B1 = 4'b1000;
    localparam logic [3:0] B2 = 4'b0100;
    localparam logic [3:0] B3 = 4'b0010;
    localparam logic [3:0] B4 = 4'b0001;

    beat_sequencer u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step      (step),
        .stop      (stop),
        .halt      (halt),
        .resume    (resume),
        .slow      (slow),
        .quick     (quick),
        .busy      (busy),
        .halted    (halted),
        .cycle_cnt (cycle_cnt)
    );

    beat_sequencer #(.CNT_W(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step      (step),
        .stop      (stop),
        .halt      (halt),
        .resume    (resume),
        .slow      (slow2),
        .quick     (quick2),
        .busy      (busy2),
        .halted    (halted2),
        .cycle_cnt (cnt2)
    );

    always #5 clk = ~clk;

    // Drive one clock of inputs and queue the outputs expected after that edge.
    task automatic t(input logic [4:0] in, input logic [3:0] es,
                     input int ec, input logic eh = 1'b0);
        exp_t e;
        @(negedge clk);
        {start, step, stop, halt, resume} = in;
        e.id = vec_n;
        e.s  = es;
        e.bz = |es;
        e.q  = (|es) & ~ec[0];
        e.h  = eh;
        e.c  = 8'(ec);
        vec_n++;
        q_exp.push_back(e);
    endtask

    task automatic chk_zero(input string name);
        compared++;
        if ({slow, quick, busy, halted, cycle_cnt} !== 15'd0) begin
            mismatched++;
            $display("FAIL %s: got slow=%b q=%b busy=%b h=%b cnt=%0d want all 0",
                     name, slow, quick, busy, halted, cycle_cnt);
        end
        compared++;
        if ({slow2, quick2, busy2, halted2, cnt2} !== 9'd0) begin
            mismatched++;
            $display("FAIL %s_w2: got slow=%b q=%b busy=%b h=%b cnt=%0d want all 0",
                     name, slow2, quick2, busy2, halted2, cnt2);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                compared++;
                if ({slow, quick, busy, halted, cycle_cnt} !==
                    {e.s, e.q, e.bz, e.h, e.c}) begin
                    mismatched++;
                    $display("FAIL vec%0d: got slow=%b q=%b busy=%b h=%b cnt=%0d want slow=%b q=%b busy=%b h=%b cnt=%0d",
                             e.id, slow, quick, busy, halted, cycle_cnt,
                             e.s, e.q, e.bz, e.h, e.c);
                end
                compared++;
                if ({slow2, quick2, busy2, halted2, cnt2} !==
                    {e.s, e.q, e.bz, e.h, e.c[1:0]}) begin
                    mismatched++;
                    $display("FAIL vec%0d_w2: got slow=%b q=%b busy=%b h=%b cnt=%0d want slow=%b q=%b busy=%b h=%b cnt=%0d",
                             e.id, slow2, quick2, busy2, halted2, cnt2,
                             e.s, e.q, e.bz, e.h, e.c[1:0]);
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b0;
        {start, step, stop, halt, resume} = N;
        #1;
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // continuous run, ignored start/step, early halt, stop at T2
        t(ST, B1, 0); t(N, B2, 0); t(N, B3, 0); t(N, B4, 0);
        t(N, B1, 1); t(ST | SP, B2, 1); t(N, B3, 1); t(HL, B4, 1);
        t(N, B1, 2); t(SO, B2, 2); t(N, B3, 2); t(N, B4, 2);
        t(N, Z, 3); t(SO | RS | HL, Z, 3);

        // stop on the T4 edge
        t(ST, B1, 3); t(N, B2, 3); t(N, B3, 3); t(N, B4, 3);
        t(SO, Z, 4); t(N, Z, 4);

        // pending stop must not leak into the next run
        t(ST, B1, 4); t(N, B2, 4); t(N, B3, 4); t(N, B4, 4);
        t(N, B1, 5); t(SO, B2, 5); t(N, B3, 5); t(N, B4, 5);
        t(N, Z, 6);

        // two single steps
        t(SP, B1, 6); t(N, B2, 6); t(N, B3, 6); t(N, B4, 6);
        t(N, Z, 7);
        t(SP, B1, 7); t(ST, B2, 7); t(N, B3, 7); t(N, B4, 7);
        t(N, Z, 8);

        // start+step together runs; halt held from T2
        t(ST | SP, B1, 8); t(N, B2, 8); t(N, B3, 8); t(N, B4, 8);
        t(N, B1, 9); t(HL, B2, 9); t(HL, B3, 9); t(HL, B4, 9);
`ifdef BEAT_SEQ_HALT_EN
        t(HL, Z, 10, 1'b1); t(ST, Z, 10, 1'b1); t(SP, Z, 10, 1'b1);
        t(RS, Z, 10); t(SO, Z, 10); t(N, Z, 10);
        b = 10;
`else
        t(HL, B1, 10); t(ST, B2, 10); t(SP, B3, 10);
        t(RS, B4, 10); t(SO, Z, 11); t(N, Z, 11);
        b = 11;
`endif

        // asynchronous reset in T3
        t(ST, B1, b); t(N, B2, b); t(N, B3, b);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        t(N, Z, 0);
        t(ST, B1, 0); t(N, B2, 0);

        for (int i = 0; i < 10; i++) begin
            if (q_exp.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (q_exp.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending want 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
